// File: rtl/rom_fetch_arbiter.sv
// Two-port round-robin arbiter in front of a single-port combinational instruction ROM.
// Each port has a registered response slot that holds until the requester accepts it.
module rom_fetch_arbiter #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_OFFSET = 32'h8000_0000,
    parameter int unsigned           MEM_SIZE   = 65536
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  p0_req_valid_i,
    output logic                  p0_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    output logic                  p0_rsp_valid_o,
    input  logic                  p0_rsp_ready_i,
    output logic [DATA_WIDTH-1:0] p0_rsp_data_o,
    output logic                  p0_rsp_err_o,
    input  logic                  p1_req_valid_i,
    output logic                  p1_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    output logic                  p1_rsp_valid_o,
    input  logic                  p1_rsp_ready_i,
    output logic [DATA_WIDTH-1:0] p1_rsp_data_o,
    output logic                  p1_rsp_err_o,
    output logic                  mem_ce_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [15:0]           conflict_cnt_o
);

    // Window bounds carry one extra bit so OFFSET+SIZE cannot wrap.
    localparam logic [ADDR_WIDTH:0] LP_LO = {1'b0, MEM_OFFSET};
    localparam logic [ADDR_WIDTH:0] LP_HI = LP_LO + (ADDR_WIDTH+1)'(MEM_SIZE);

    function automatic logic f_bad(input logic [ADDR_WIDTH-1:0] a);
        f_bad = (a[1:0] != 2'b00) || ({1'b0, a} < LP_LO) || ({1'b0, a} >= LP_HI);
    endfunction

    logic                  r_p0_valid, r_p1_valid;
    logic [DATA_WIDTH-1:0] r_p0_data, r_p1_data;
    logic                  r_p0_err, r_p1_err;
    logic                  r_last_p1;
    logic [15:0]           r_conflict_cnt;

    logic                  w_elig0, w_elig1, w_both;
    logic                  w_grant0, w_grant1, w_any;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_cap_data;

    always_comb begin
        w_elig0    = p0_req_valid_i & (~r_p0_valid | p0_rsp_ready_i);
        w_elig1    = p1_req_valid_i & (~r_p1_valid | p1_rsp_ready_i);
        w_both     = w_elig0 & w_elig1;
        // On conflict the port that did not win last time gets the grant.
        w_grant0   = w_elig0 & (~w_elig1 | r_last_p1);
        w_grant1   = w_elig1 & (~w_elig0 | ~r_last_p1);
        w_any      = w_grant0 | w_grant1;
        w_addr     = w_grant1 ? p1_addr_i : p0_addr_i;
        w_err      = f_bad(w_addr);
        w_cap_data = w_err ? '0 : mem_data_i;
    end

    assign p0_req_ready_o = w_grant0;
    assign p1_req_ready_o = w_grant1;
    assign mem_ce_o       = w_any & ~w_err;
    assign mem_addr_o     = w_any ? w_addr : '0;
    assign p0_rsp_valid_o = r_p0_valid;
    assign p0_rsp_data_o  = r_p0_data;
    assign p0_rsp_err_o   = r_p0_err;
    assign p1_rsp_valid_o = r_p1_valid;
    assign p1_rsp_data_o  = r_p1_data;
    assign p1_rsp_err_o   = r_p1_err;
    assign conflict_cnt_o = r_conflict_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_p0_valid <= 1'b0;
            r_p0_data  <= '0;
            r_p0_err   <= 1'b0;
        end else if (w_grant0) begin
            r_p0_valid <= 1'b1;
            r_p0_data  <= w_cap_data;
            r_p0_err   <= w_err;
        end else if (p0_rsp_ready_i) begin
            r_p0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_p1_valid <= 1'b0;
            r_p1_data  <= '0;
            r_p1_err   <= 1'b0;
        end else if (w_grant1) begin
            r_p1_valid <= 1'b1;
            r_p1_data  <= w_cap_data;
            r_p1_err   <= w_err;
        end else if (p1_rsp_ready_i) begin
            r_p1_valid <= 1'b0;
        end
    end

    // r_last_p1 resets high so port 0 wins the first conflict.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_last_p1      <= 1'b1;
            r_conflict_cnt <= '0;
        end else begin
            if (w_any) begin
                r_last_p1 <= w_grant1;
            end
            if (w_both && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Randomized bench for rom_fetch_arbiter: a per-cycle behavioural model checked at
// every falling edge, plus directed scenarios with hand-computed expectations.
module tb_rom_fetch_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        p0_req_valid_i = 1'b0, p1_req_valid_i = 1'b0;
    logic        p0_rsp_ready_i = 1'b0, p1_rsp_ready_i = 1'b0;
    logic [31:0] p0_addr_i = '0, p1_addr_i = '0;
    logic        p0_req_ready_o, p1_req_ready_o;
    logic        p0_rsp_valid_o, p1_rsp_valid_o;
    logic [31:0] p0_rsp_data_o, p1_rsp_data_o;
    logic        p0_rsp_err_o, p1_rsp_err_o;
    logic        mem_ce_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic [15:0] conflict_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    rom_fetch_arbiter dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .p0_req_valid_i(p0_req_valid_i), .p0_req_ready_o(p0_req_ready_o), .p0_addr_i(p0_addr_i),
        .p0_rsp_valid_o(p0_rsp_valid_o), .p0_rsp_ready_i(p0_rsp_ready_i),
        .p0_rsp_data_o(p0_rsp_data_o), .p0_rsp_err_o(p0_rsp_err_o),
        .p1_req_valid_i(p1_req_valid_i), .p1_req_ready_o(p1_req_ready_o), .p1_addr_i(p1_addr_i),
        .p1_rsp_valid_o(p1_rsp_valid_o), .p1_rsp_ready_i(p1_rsp_ready_i),
        .p1_rsp_data_o(p1_rsp_data_o), .p1_rsp_err_o(p1_rsp_err_o),
        .mem_ce_o(mem_ce_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .conflict_cnt_o(conflict_cnt_o)
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    // ROM contents: word 0x13 at the base, a distinctive pattern elsewhere.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0013;
        return {a[15:0] ^ 16'h5A5A, a[31:16]};
    endfunction

    assign mem_data_i = rom_word(mem_addr_o);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        longint unsigned ua;
        ua = longint'(a);
        return (a[1:0] != 2'b00) || (ua < 64'h8000_0000) || (ua >= 64'h8000_0000 + 65536);
    endfunction

    // Behavioural model: response slot contents per port, last winner, conflict count.
    bit          m_valid[2];
    logic [31:0] m_data[2];
    bit          m_err[2];
    int          m_last;
    int          m_cnt;

    always @(negedge clk_i) begin : model
        bit          v_in[2], r_in[2], elig[2], bad;
        logic [31:0] a_in[2], ga;
        int          g;
        if (!rst_n_i) begin
            for (int n = 0; n < 2; n++) begin
                m_valid[n] = 0; m_data[n] = '0; m_err[n] = 0;
            end
            m_last = 1;
            m_cnt  = 0;
            check("rst_p0_valid", p0_rsp_valid_o, 0);
            check("rst_p1_valid", p1_rsp_valid_o, 0);
            check("rst_p0_data", p0_rsp_data_o, 0);
            check("rst_p1_data", p1_rsp_data_o, 0);
            check("rst_cnt", conflict_cnt_o, 0);
        end else begin
            v_in[0] = p0_req_valid_i; v_in[1] = p1_req_valid_i;
            r_in[0] = p0_rsp_ready_i; r_in[1] = p1_rsp_ready_i;
            a_in[0] = p0_addr_i;      a_in[1] = p1_addr_i;
            check("p0_rsp_valid", p0_rsp_valid_o, m_valid[0]);
            check("p1_rsp_valid", p1_rsp_valid_o, m_valid[1]);
            check("p0_rsp_data", p0_rsp_data_o, m_data[0]);
            check("p1_rsp_data", p1_rsp_data_o, m_data[1]);
            check("p0_rsp_err", p0_rsp_err_o, m_err[0]);
            check("p1_rsp_err", p1_rsp_err_o, m_err[1]);
            check("conflict_cnt", conflict_cnt_o, m_cnt);
            for (int n = 0; n < 2; n++) elig[n] = v_in[n] && (!m_valid[n] || r_in[n]);
            if (elig[0] && elig[1]) g = 1 - m_last;
            else if (elig[0]) g = 0;
            else if (elig[1]) g = 1;
            else g = -1;
            check("p0_req_ready", p0_req_ready_o, g == 0);
            check("p1_req_ready", p1_req_ready_o, g == 1);
            if (g >= 0) begin
                ga  = a_in[g];
                bad = addr_bad(ga);
                check("mem_ce", mem_ce_o, !bad);
                check("mem_addr", mem_addr_o, ga);
            end else begin
                ga  = '0;
                bad = 0;
                check("mem_ce_idle", mem_ce_o, 0);
                check("mem_addr_idle", mem_addr_o, 0);
            end
            if (elig[0] && elig[1] && m_cnt < 65535) m_cnt++;
            for (int n = 0; n < 2; n++) begin
                if (g == n) begin
                    m_valid[n] = 1;
                    m_data[n]  = bad ? 32'h0 : rom_word(ga);
                    m_err[n]   = bad;
                end else if (r_in[n]) begin
                    m_valid[n] = 0;
                end
            end
            if (g >= 0) m_last = g;
        end
    end

    // Driver tasks
    task automatic idle_inputs();
        p0_req_valid_i = 0; p1_req_valid_i = 0;
        p0_rsp_ready_i = 1; p1_rsp_ready_i = 1;
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_n_i = 0;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_n_i = 1;
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0: begin a = 32'h8000_0000 + $urandom_range(0, 16'hFFFF); a[0] = 1'b1; end
            1: a = $urandom & 32'h7FFF_FFFC;
            2: a = 32'h8001_0000 + ($urandom_range(0, 16'hFFFF) << 2);
            3: a = 32'h8000_FFFC;
            4: a = 32'h8001_0000;
            5: a = 32'hFFFF_FFFC;
            default: a = 32'h8000_0000 + ($urandom_range(0, 16383) << 2);
        endcase
        return a;
    endfunction

    logic [31:0] bad_addrs[3];

    initial begin
        bad_addrs[0] = 32'h8000_0002;
        bad_addrs[1] = 32'h7FFF_FFFC;
        bad_addrs[2] = 32'h8001_0000;
        idle_inputs();
        do_reset();

        // Single fetch at the ROM base
        p0_req_valid_i = 1; p0_addr_i = 32'h8000_0000;
        @(negedge clk_i);
        check("t1_ready", p0_req_ready_o, 1);
        check("t1_ce", mem_ce_o, 1);
        @(posedge clk_i); #1; p0_req_valid_i = 0;
        @(negedge clk_i);
        check("t1_rsp_valid", p0_rsp_valid_o, 1);
        check("t1_rsp_data", p0_rsp_data_o, 32'h0000_0013);
        check("t1_rsp_err", p0_rsp_err_o, 0);

        // Continuous conflict alternates starting with port 0
        do_reset();
        p0_req_valid_i = 1; p0_addr_i = 32'h8000_0004;
        p1_req_valid_i = 1; p1_addr_i = 32'h8000_0100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check("t2_p0_grant", p0_req_ready_o, (k % 2) == 0);
            check("t2_p1_grant", p1_req_ready_o, (k % 2) == 1);
            @(posedge clk_i); #1;
        end
        idle_inputs();
        @(negedge clk_i);
        check("t2_cnt", conflict_cnt_o, 4);
        check("t2_p0_data", p0_rsp_data_o, {16'h0004 ^ 16'h5A5A, 16'h8000});

        // Port 0 stalls its response; port 1 keeps getting grants
        @(posedge clk_i); #1;
        p0_req_valid_i = 1; p0_addr_i = 32'h8000_0008;
        @(posedge clk_i); #1;
        p0_rsp_ready_i = 0;
        p1_req_valid_i = 1; p1_addr_i = 32'h8000_0100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("t3_p0_blocked", p0_req_ready_o, 0);
            check("t3_p1_grant", p1_req_ready_o, 1);
            check("t3_p0_hold", p0_rsp_data_o, {16'h0008 ^ 16'h5A5A, 16'h8000});
            @(posedge clk_i); #1;
        end
        idle_inputs();

        // Misaligned and out-of-window addresses
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            p0_req_valid_i = 1; p0_addr_i = bad_addrs[k];
            @(negedge clk_i);
            check("t4_ready", p0_req_ready_o, 1);
            check("t4_ce", mem_ce_o, 0);
            @(posedge clk_i); #1;
            p0_req_valid_i = 0;
            @(negedge clk_i);
            check("t4_err", p0_rsp_err_o, 1);
            check("t4_data", p0_rsp_data_o, 0);
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_i); #1;
            p0_req_valid_i = ($urandom_range(0, 3) != 0);
            p1_req_valid_i = ($urandom_range(0, 3) != 0);
            p0_rsp_ready_i = ($urandom_range(0, 3) != 0);
            p1_rsp_ready_i = ($urandom_range(0, 3) != 0);
            p0_addr_i = pick_addr();
            p1_addr_i = pick_addr();
        end
        @(posedge clk_i); #1;
        idle_inputs();

        // Asynchronous reset while port 1 holds a response
        @(posedge clk_i); #1;
        p1_req_valid_i = 1; p1_addr_i = 32'h8000_0100; p1_rsp_ready_i = 0;
        @(posedge clk_i); #1;
        p1_req_valid_i = 0;
        @(negedge clk_i);
        check("t5_p1_valid_pre", p1_rsp_valid_o, 1);
        #2;
        rst_n_i = 0;
        idle_inputs();
        #1;
        check("t5_p1_valid_async", p1_rsp_valid_o, 0);
        check("t5_p0_valid_async", p0_rsp_valid_o, 0);
        @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_n_i = 1;
        p0_req_valid_i = 1; p0_addr_i = 32'h8000_0010;
        p1_req_valid_i = 1; p1_addr_i = 32'h8000_0020;
        @(negedge clk_i);
        check("t5_first_p0", p0_req_ready_o, 1);
        check("t5_first_p1", p1_req_ready_o, 0);

        // Saturation of the conflict counter
        repeat (66000) @(posedge clk_i);
        @(negedge clk_i);
        check("t6_saturated", conflict_cnt_o, 16'hFFFF);
        @(posedge clk_i); #1;
        idle_inputs();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
